// File: rtl/cache_pkg.sv
// Shared geometry, fill-state encoding and address slicing for the 2-way, 2KB, 16B-block cache.
package cache_pkg;

    localparam int unsigned WORD_W          = 16;
    localparam int unsigned OFFSET_W        = 4;
    localparam int unsigned SET_W           = 6;
    localparam int unsigned TAG_W           = 6;
    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned WORD_IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    function automatic logic [SET_W-1:0] set_of(input logic [15:0] addr);
        return addr[OFFSET_W +: SET_W];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [15:0] addr);
        return addr[OFFSET_W+SET_W +: TAG_W];
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Word-index counter for the fill engine: synchronous clear, count enable, terminal-count decode.
module fill_counter (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                en,
    output logic [cache_pkg::WORD_IDX_W-1:0]    cnt,
    output logic                                tc_c
);

    localparam int unsigned CNT_W = cache_pkg::WORD_IDX_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc_c = (cnt == '1);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches an 8-word block from memory, streams words into the
// data array as they return, and writes the tag once the last word has landed.
module cache_fill_fsm #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned MEM_LATENCY     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_detected,
    input  logic [ADDR_W-1:0]                 miss_address,
    input  logic                              memory_data_valid,
    input  logic [cache_pkg::WORD_W-1:0]      memory_data_out,
    output logic                              fsm_busy,
    output logic                              memory_read_en,
    output logic [ADDR_W-1:0]                 memory_address,
    output logic                              write_data_array,
    output logic [WORDS_PER_BLOCK-1:0]        word_sel,
    output logic [cache_pkg::WORD_W-1:0]      fill_data,
    output logic                              write_tag_array,
    output logic [cache_pkg::SET_W-1:0]       fill_set,
    output logic [cache_pkg::TAG_W-1:0]       fill_tag,
    output logic                              fill_done
);

    import cache_pkg::*;

    fill_state_e             state_q;
    fill_state_e             state_d;
    logic [ADDR_W-1:0]       base_q;
    logic [WORD_W-1:0]       fill_data_q;
    logic                    issue_done_q;
    logic                    wr_pend_q;
    logic [WORD_IDX_W-1:0]   issue_cnt;
    logic [WORD_IDX_W-1:0]   ret_cnt;
    logic                    issue_tc;
    logic                    ret_tc;
    logic                    start;
    logic                    issue_en;
    logic                    ret_last;
    logic                    accept;
    logic                    unused_offset_bits;

    // Byte offset within the block never reaches memory.
    assign unused_offset_bits = ^miss_address[OFFSET_W-1:0];

    assign start    = (state_q == IDLE) && miss_detected;
    assign issue_en = (state_q == FILL) && !issue_done_q;
    assign ret_last = wr_pend_q && ret_tc;
    // A valid arriving alongside the final write would be a ninth word; drop it.
    assign accept   = (state_q == FILL) && memory_data_valid && !ret_last;

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (start),
        .en    (issue_en),
        .cnt   (issue_cnt),
        .tc_c  (issue_tc)
    );

    fill_counter u_ret_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (start),
        .en    (wr_pend_q),
        .cnt   (ret_cnt),
        .tc_c  (ret_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_detected) state_d = FILL;
            FILL:    if (ret_last)      state_d = DONE;
            DONE:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Block base, issue-complete flag and the one-cycle return pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q       <= '0;
            issue_done_q <= 1'b0;
            wr_pend_q    <= 1'b0;
            fill_data_q  <= '0;
        end else begin
            if (start) begin
                base_q       <= {miss_address[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                issue_done_q <= 1'b0;
            end else if (issue_en && issue_tc) begin
                issue_done_q <= 1'b1;
            end
            wr_pend_q <= accept;
            if (accept) begin
                fill_data_q <= memory_data_out;
            end
        end
    end

    always_comb begin
        fsm_busy         = (state_q != IDLE) || miss_detected;
        memory_read_en   = issue_en;
        memory_address   = '0;
        write_data_array = wr_pend_q;
        word_sel         = '0;
        fill_data        = fill_data_q;
        write_tag_array  = ret_last;
        fill_set         = set_of(16'(base_q));
        fill_tag         = tag_of(16'(base_q));
        fill_done        = (state_q == DONE);
        if (issue_en) begin
            memory_address = base_q + ADDR_W'({issue_cnt, 1'b0});
        end
        if (wr_pend_q) begin
            word_sel = WORDS_PER_BLOCK'(1) << ret_cnt;
        end
    end

    // The first return of a fill can never beat the nominal memory latency.
    always_ff @(posedge clk) begin
        if (rst && (state_q == FILL) && memory_data_valid && !wr_pend_q
            && (ret_cnt == '0) && !issue_done_q) begin
            assert (32'(issue_cnt) >= MEM_LATENCY);
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: latency-table memory model, event logs, hand-computed expectations.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        mem_valid;
    logic        stray_valid;
    logic [15:0] mem_data;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [7:0]  word_sel;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [5:0]  fill_set;
    logic [5:0]  fill_tag;
    logic        fill_done;

    cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (mem_valid | stray_valid),
        .memory_data_out   (mem_data),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_sel          (word_sel),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .fill_set          (fill_set),
        .fill_tag          (fill_tag),
        .fill_done         (fill_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    int          due_q[$];
    logic [15:0] dat_q[$];
    logic [7:0]  wr_sel_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          tag_cyc_q[$];
    logic [5:0]  tag_set_q[$];
    logic [5:0]  tag_tg_q[$];
    int          done_q[$];
    int          lat_tab[8];
    int          exp_ret_off[8];
    int          rd_idx = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({memory_read_en, memory_address, write_data_array, word_sel, fill_data,
                    write_tag_array, fill_set, fill_tag, fill_done, fsm_busy});
    endfunction

    function automatic void clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete(); due_q.delete(); dat_q.delete();
        wr_sel_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        tag_cyc_q.delete(); tag_set_q.delete(); tag_tg_q.delete(); done_q.delete();
        rd_idx = 0;
    endfunction

    // Memory model and event monitor: sample at the falling edge, drive valid for this cycle.
    always @(negedge clk) begin
        mem_valid = 1'b0;
        mem_data  = 16'hDEAD;
        if (rst && memory_read_en) begin
            rd_addr_q.push_back(memory_address);
            rd_cyc_q.push_back(cyc);
            due_q.push_back(cyc + lat_tab[rd_idx % 8]);
            dat_q.push_back(memory_address ^ 16'hC3C3);
            rd_idx++;
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            mem_valid = 1'b1;
            mem_data  = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
        if (write_data_array) begin
            wr_sel_q.push_back(word_sel);
            wr_data_q.push_back(fill_data);
            wr_cyc_q.push_back(cyc);
        end
        if (write_tag_array) begin
            tag_cyc_q.push_back(cyc);
            tag_set_q.push_back(fill_set);
            tag_tg_q.push_back(fill_tag);
        end
        if (fill_done) done_q.push_back(cyc);
    end

    // Raise miss in one cycle, then run until fsm_busy drops; busy_cnt counts busy cycles from the miss cycle.
    task automatic run_fill(input string nm, input logic [15:0] addr2, input int drop_off,
                            input int budget, output int m, output int busy_cnt);
        bit idle_seen;
        idle_seen = 1'b0;
        busy_cnt  = 0;
        @(negedge clk);
        miss_detected = 1'b1;
        m = cyc;
        #1;
        if (fsm_busy) busy_cnt++;
        for (int n = 1; n <= budget && !idle_seen; n++) begin
            @(negedge clk);
            if (n == 1) miss_address = addr2;
            if (n == drop_off) miss_detected = 1'b0;
            #1;
            if (fsm_busy) busy_cnt++;
            else idle_seen = 1'b1;
        end
        miss_detected = 1'b0;
        check({nm, "_idle_reached"}, 64'(idle_seen), 64'(1));
    endtask

    task automatic check_fill(input string nm, input int m, input logic [15:0] base,
                              input logic [5:0] set_e, input logic [5:0] tag_e,
                              input int ri, input int wi, input int ti, input int di);
        for (int k = 0; k < 8; k++) begin
            if (ri + k < rd_addr_q.size()) begin
                check($sformatf("%s_rd_addr%0d", nm, k), 64'(rd_addr_q[ri+k]), 64'(base + 16'(2*k)));
                check($sformatf("%s_rd_cyc%0d", nm, k), 64'(rd_cyc_q[ri+k]), 64'(m + 1 + k));
            end
            if (wi + k < wr_sel_q.size()) begin
                check($sformatf("%s_wr_sel%0d", nm, k), 64'(wr_sel_q[wi+k]), 64'(8'(1) << k));
                check($sformatf("%s_wr_data%0d", nm, k), 64'(wr_data_q[wi+k]),
                      64'((base + 16'(2*k)) ^ 16'hC3C3));
                check($sformatf("%s_wr_cyc%0d", nm, k), 64'(wr_cyc_q[wi+k]), 64'(m + exp_ret_off[k] + 1));
            end
        end
        if (ti < tag_cyc_q.size()) begin
            check({nm, "_tag_cyc"}, 64'(tag_cyc_q[ti]), 64'(m + exp_ret_off[7] + 1));
            check({nm, "_fill_set"}, 64'(tag_set_q[ti]), 64'(set_e));
            check({nm, "_fill_tag"}, 64'(tag_tg_q[ti]), 64'(tag_e));
        end
        if (di < done_q.size()) begin
            check({nm, "_done_cyc"}, 64'(done_q[di]), 64'(m + exp_ret_off[7] + 2));
        end
    endtask

    task automatic check_counts(input string nm, input int rd, input int wr, input int tg, input int dn);
        check({nm, "_rd_count"}, 64'(rd_addr_q.size()), 64'(rd));
        check({nm, "_wr_count"}, 64'(wr_sel_q.size()), 64'(wr));
        check({nm, "_tag_count"}, 64'(tag_cyc_q.size()), 64'(tg));
        check({nm, "_done_count"}, 64'(done_q.size()), 64'(dn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int busy;
        rst           = 1'b0;
        miss_detected = 1'b0;
        miss_address  = 16'h0000;
        stray_valid   = 1'b0;
        mem_valid     = 1'b0;
        mem_data      = 16'hDEAD;
        lat_tab       = '{4, 4, 4, 4, 4, 4, 4, 4};
        exp_ret_off   = '{5, 6, 7, 8, 9, 10, 11, 12};

        // Reset state: everything zero, busy still follows miss combinationally.
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", out_vec(), 64'(0));
        miss_detected = 1'b1;
        #1 check("reset_busy_on_miss", 64'(fsm_busy), 64'(1));
        miss_detected = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);

        // Basic fill, fixed latency 4.
        clear_logs();
        miss_address = 16'h1236;
        run_fill("basic", 16'h1236, 1, 40, m, busy);
        check("basic_busy_cycles", 64'(busy), 64'(15));
        check_counts("basic", 8, 8, 1, 1);
        check_fill("basic", m, 16'h1230, 6'h23, 6'h04, 0, 0, 0, 0);
        repeat (4) @(negedge clk);

        // Back-to-back: miss held high, second block accepted only after fill_done.
        clear_logs();
        miss_address = 16'h1236;
        run_fill("b2b", 16'h0040, 16, 60, m, busy);
        check("b2b_busy_cycles", 64'(busy), 64'(30));
        check_counts("b2b", 16, 16, 2, 2);
        check_fill("b2b_first", m, 16'h1230, 6'h23, 6'h04, 0, 0, 0, 0);
        check_fill("b2b_second", m + 15, 16'h0040, 6'h04, 6'h00, 8, 8, 1, 1);
        repeat (4) @(negedge clk);

        // Wrap at the top of the address space.
        clear_logs();
        miss_address = 16'hFFF9;
        run_fill("wrap", 16'hFFF9, 1, 40, m, busy);
        check("wrap_busy_cycles", 64'(busy), 64'(15));
        check_counts("wrap", 8, 8, 1, 1);
        check_fill("wrap", m, 16'hFFF0, 6'h3F, 6'h3F, 0, 0, 0, 0);
        repeat (4) @(negedge clk);

        // Reset after the third data write, then late and stray returns.
        clear_logs();
        miss_address = 16'h0A5C;
        @(negedge clk);
        miss_detected = 1'b1;
        m = cyc;
        @(negedge clk);
        miss_detected = 1'b0;
        repeat (7) @(negedge clk);
        #1 check("rstmid_writes_before", 64'(wr_sel_q.size()), 64'(3));
        rst = 1'b0;
        #1 check("rstmid_outputs_zero", out_vec(), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stray_valid = (i % 2 == 0);
            #1 check($sformatf("rstmid_no_write%0d", i), 64'(write_data_array), 64'(0));
        end
        stray_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1 check("rstmid_busy", 64'(fsm_busy), 64'(0));
        check_counts("rstmid", 8, 3, 0, 0);

        // Irregular return spacing.
        clear_logs();
        lat_tab      = '{4, 6, 6, 9, 9, 9, 10, 10};
        exp_ret_off  = '{5, 8, 9, 13, 14, 15, 17, 18};
        miss_address = 16'h2468;
        run_fill("irreg", 16'h2468, 1, 60, m, busy);
        check("irreg_busy_cycles", 64'(busy), 64'(21));
        check_counts("irreg", 8, 8, 1, 1);
        check_fill("irreg", m, 16'h2460, 6'h06, 6'h09, 0, 0, 0, 0);
        repeat (4) @(negedge clk);

        // Stray valid in IDLE.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stray_valid = (i < 3);
            #1;
            check($sformatf("stray_no_write%0d", i), 64'(write_data_array), 64'(0));
            check($sformatf("stray_not_busy%0d", i), 64'(fsm_busy), 64'(0));
        end
        stray_valid = 1'b0;
        @(negedge clk);
        #1 check_counts("stray", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler for the 2-way set-associative, 2KB, 16B-block cache.
- On a miss, fetches the whole 8-word block from multi-cycle main memory and streams each returned word into the cache data array.
- Writes the tag array once the last word has landed.
- Sits between the cache wrapper (data/metadata arrays) and main memory; stalls the pipeline while busy.

Parameters:
- ADDR_W, 16: byte address width.
- WORDS_PER_BLOCK, 8: 16-bit words per block (16B block).
- MEM_LATENCY, 4: nominal memory read latency. Documentation/assertion only; the FSM relies on memory_data_valid, not on cycle counting.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- miss_detected  in  1  cache miss on the current access.
- miss_address  in  16  byte address of the missing access.
- memory_data_valid  in  1  memory_data_out holds a returned read word.
- memory_data_out  in  16  word returned by memory.
- fsm_busy  out  1  stall request to the pipeline.
- memory_read_en  out  1  issue a memory read this cycle.
- memory_address  out  16  address of the issued read.
- write_data_array  out  1  write fill_data into the data array.
- word_sel  out  8  one-hot word enable for the data array write.
- fill_data  out  16  word to write (registered copy of memory_data_out).
- write_tag_array  out  1  write the tag array (block now valid).
- fill_set  out  6  set index of the block being filled (base[9:4]).
- fill_tag  out  6  tag of the block being filled (base[15:10]).
- fill_done  out  1  one-cycle pulse when the fill is complete.

Behaviour:
- Reset (rst=0, async): state=IDLE, issue_cnt=0, ret_cnt=0, base=0. All outputs 0, except fsm_busy, which follows the combinational rule below.
- Address decode: base = {miss_address[15:4], 4'b0000}. Bits [3:0] are ignored, including bit 0.
- fsm_busy = (state != IDLE) | (state == IDLE & miss_detected). This is combinational so the pipeline stalls in the miss cycle itself.
- IDLE:
  - miss_detected=1 at the clock edge: capture base, clear both counters, go to FILL.
  - memory_data_valid is ignored in IDLE; no array writes occur.
- FILL:
  - Issue side: memory_read_en=1 while issue_cnt<8; memory_address = base + 2*issue_cnt (16-bit, wraps mod 2^16). issue_cnt increments each cycle. One read per cycle, 8 consecutive cycles starting the cycle after entry.
  - Return side: each cycle with memory_data_valid=1, register memory_data_out into fill_data. In the next cycle, assert write_data_array=1 with word_sel = 1 << ret_cnt_prev, then increment ret_cnt.
  - The write is registered, so it lands 1 cycle after valid.
  - Returns are in order; word k is always written to word_sel bit k.
  - Issue and return may overlap in the same cycle.
- Last word: the cycle the 8th data write occurs, also assert write_tag_array=1. fill_set/fill_tag are held stable from FILL entry until IDLE. Then go to DONE.
- DONE: fill_done=1 for exactly one cycle; fsm_busy=1; then go to IDLE.
- miss_detected is ignored in FILL and DONE. A new miss is only accepted once back in IDLE (earliest 1 cycle after fill_done).
- Minimum fill time with MEM_LATENCY=4 (returns 4 cycles after issue): 8 issue cycles + 4 latency + 1 register + 1 DONE ≈ 14 cycles of busy after the miss cycle.
- Reset mid-fill:
  - Returns immediately to IDLE and drops all strobes.
  - write_tag_array was never asserted, so the partially written block stays invalid.
  - Late memory_data_valid pulses after reset are ignored (IDLE).
- Wrap-around: base 0xFFF0 issues 0xFFF0..0xFFFE; no carry beyond bit 15.
- Extra memory_data_valid after the 8th return (state DONE/IDLE): ignored.

Decomposition:
- Package cache_pkg holds:
  - OFFSET_W=4, SET_W=6, TAG_W=6, WORDS_PER_BLOCK=8, WORD_IDX_W=3.
  - The fill state enum {IDLE, FILL, DONE}.
  - The set/tag slice helpers.
- One sub-module: fill_counter, a 3-bit counter with clear, enable, async active-low reset and a terminal-count flag. It is instantiated twice, as issue_cnt and ret_cnt.

Test Plan:
1. Basic fill:
   - Stimulus: miss_address=0x1236; memory model returns each read 4 cycles after issue.
   - Required: reads at 0x1230,0x1232,…,0x123E on 8 consecutive cycles; 8 data writes with word_sel 0x01→0x80 in order; write_tag_array with the 8th write; fill_set=0x23, fill_tag=0x04; fill_done one cycle later; fsm_busy high from the miss cycle through DONE.
2. Back-to-back misses:
   - Stimulus: miss_detected held high throughout, second address 0x0040.
   - Required: the second fill starts only after fill_done; issues 0x0040..0x004E; no reads overlap the first fill.
3. Wrap:
   - Stimulus: miss_address=0xFFF9.
   - Required: addresses 0xFFF0..0xFFFE; fill_tag=0x3F, fill_set=0x3F.
4. Reset mid-fill:
   - Stimulus: assert rst low after the 3rd data write; release; send 5 more memory_data_valid pulses.
   - Required: all outputs 0 immediately; no write_tag_array ever; no data writes after reset.
5. Irregular latency:
   - Stimulus: valid pulses with gaps (returns at +4,+6,+6,+9,… cycles).
   - Required: each word still written to the correct word_sel; write_tag_array only on the 8th return.
6. Stray valid in IDLE:
   - Stimulus: memory_data_valid=1 with no miss pending.
   - Required: write_data_array stays 0, fsm_busy=0.
